// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: y = a - b, one bit per clock LSB first, with a
// start/busy handshake and a one-cycle done pulse when the result lands.
module serial_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_bi,
    input  logic [WIDTH-1:0] b_bi,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] y_bo,
    output logic             borrow_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   a_sr, a_sr_n;
    logic [WIDTH-1:0]   b_sr, b_sr_n;
    logic [WIDTH-1:0]   res_sr, res_sr_n;
    logic               br, br_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               busy_n, done_n, borrow_n;
    logic [WIDTH-1:0]   y_n;

    // Full-subtractor cell on the current LSB of the operand shift registers
    logic diff_c, br_next_c;
    assign diff_c    = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            y_bo     <= '0;
            borrow_o <= 1'b0;
        end else begin
            state    <= state_n;
            a_sr     <= a_sr_n;
            b_sr     <= b_sr_n;
            res_sr   <= res_sr_n;
            br       <= br_n;
            cnt      <= cnt_n;
            busy_o   <= busy_n;
            done_o   <= done_n;
            y_bo     <= y_n;
            borrow_o <= borrow_n;
        end
    end

    always_comb begin
        state_n  = state;
        a_sr_n   = a_sr;
        b_sr_n   = b_sr;
        res_sr_n = res_sr;
        br_n     = br;
        cnt_n    = cnt;
        busy_n   = busy_o;
        done_n   = 1'b0;
        y_n      = y_bo;
        borrow_n = borrow_o;

        unique case (state)
            IDLE: begin
                if (start_i) begin
                    a_sr_n   = a_bi;
                    b_sr_n   = b_bi;
                    res_sr_n = '0;
                    br_n     = 1'b0;
                    cnt_n    = '0;
                    busy_n   = 1'b1;
                    state_n  = WORK;
                end
            end
            WORK: begin
                res_sr_n = {diff_c, res_sr[WIDTH-1:1]};
                a_sr_n   = a_sr >> 1;
                b_sr_n   = b_sr >> 1;
                br_n     = br_next_c;
                cnt_n    = cnt + CNT_W'(1);
                // Publish only the complete word so partial results never show
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    y_n      = {diff_c, res_sr[WIDTH-1:1]};
                    borrow_n = br_next_c;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
